pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Control block between pipeline hazard and exception sources and the PC register.
- Arbitrates simultaneous redirect requests by fixed priority and drives the PC's one-hot take* selects and stall.
- Buffers a redirect and its target payload while fetch is frozen, then issues it exactly once when fetch resumes.
- Generates the pipeline flushes for exception and eret, and keeps a saturating count of issued redirects.

Parameters:
- CNT_W, 16, width of the saturating redirect counter redirectCount.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetchBusy  in  1  instruction memory not ready; PC must hold.
- loadUseHazard  in  1  hazard unit stalls IF/ID.
- excReq  in  1  exception from MEM; excVector is fixed inside the PC.
- eretReq  in  1  eret committing.
- epcIn  in  32  return address for eret.
- branchReq  in  1  taken branch resolved in EX.
- branchImmIn  in  32  sign-extended branch offset.
- jumpRegReq  in  1  jr/jalr decoded in ID.
- jumpRegIn  in  32  register target.
- jumpImmReq  in  1  j/jal decoded in ID.
- jumpImmIn  in  26  instruction index.
- stall  out  1  to PC.stall.
- takeException, takeEret, takeBranch, takeJumpReg, takeJumpImm  out  1 each  one-hot selects to the PC.
- epc  out  32  to the PC.
- branchImmEx  out  32  to the PC.
- jumpReg  out  32  to the PC.
- jumpImm  out  26  to the PC.
- flushIf, flushId, flushEx  out  1 each  pipeline flushes.
- redirectPending  out  1  state==HOLD.
- redirectCount  out  CNT_W  issued-redirect count.

Behaviour:
- Priority, highest first: excReq > eretReq > branchReq > jumpRegReq > jumpImmReq. The winner is "sel".
- jumpRegReq and jumpImmReq are masked while loadUseHazard=1, because the ID instruction re-presents.
- At most one take* output is high in any cycle.
- States:
  - RUN: no pending redirect.
  - HOLD: pending register holds a type plus its payload, with the other payload fields zeroed.
- RUN with fetchBusy=0:
  - If sel is exception or eret, issue combinationally this cycle with stall=0, even if loadUseHazard=1.
  - Else if loadUseHazard=1: stall=1. A branchReq is latched into pending and the block moves to HOLD.
  - Else if sel exists: issue combinationally with stall=0.
  - Else: stall=0 and all take*=0.
- RUN with fetchBusy=1: stall=1, no take*. Any sel is latched into pending (type and payload) and the block moves to HOLD.
- HOLD:
  - stall=1 while fetchBusy=1 or loadUseHazard=1.
  - A new request of strictly higher priority than pending replaces it, payload included. Equal or lower priority requests are dropped.
  - When fetchBusy=0 and loadUseHazard=0: assert the pending take* for exactly one cycle, stall=0, drive the pending payload, clear pending, go to RUN.
  - An exception pending also issues while loadUseHazard=1, provided fetchBusy=0.
- Payload outputs:
  - Track the request inputs combinationally in RUN.
  - Driven from the pending register in HOLD.
  - Zero when nothing is selected.
- Flushes, asserted only in the cycle of issue:
  - exception: flushIf, flushId, flushEx all 1.
  - eret: flushIf and flushId.
  - branch and jumps: no flush (delay slot preserved).
- redirectCount increments by 1 on each issue cycle and saturates at all-ones.
- Reset (rst=0, asynchronous): state=RUN, pending cleared, redirectCount=0. All outputs 0, including stall.
- Reset mid-HOLD discards the pending redirect; it is never issued.

Test Plan:
1. rst=0 then released; no requests. Required: stall=0, all take*=0, all flushes=0, redirectCount=0.
2. RUN, branchReq=1 and jumpImmReq=1 with branchImmIn=32'h0000_1234. Required: takeBranch=1 and branchImmEx=32'h0000_1234 the same cycle; takeJumpImm=0; redirectCount=1.
3. fetchBusy=1 for 3 cycles; jumpRegReq=1 with jumpRegIn=32'h2222_2220 in cycle 1 only. Required: stall=1 for 3 cycles and redirectPending=1. In the first cycle after fetchBusy falls: takeJumpReg=1, jumpReg=32'h2222_2220, stall=0. Then RUN.
4. HOLD with a pending branch; excReq=1 arrives while fetchBusy=1. Required: pending replaced. On release: takeException=1 with flushIf, flushId and flushEx=1; takeBranch is never asserted.
5. loadUseHazard=1 with jumpImmReq=1, then eretReq=1 with epcIn=32'h1111_1110. Required: no takeJumpImm. The eret issues with stall=0, takeEret=1, epc=32'h1111_1110, flushIf and flushId=1, flushEx=0.
6. Reset asserted during HOLD with a pending branch, then released. Required: no take* ever issues and redirectCount=0. Also preload redirectCount near all-ones (e.g. CNT_W=2, 5 issues) and check it holds at 3.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Redirect arbiter in front of the PC: picks the highest-priority redirect,
// parks it while fetch is frozen, and issues it exactly once with its flushes.
module pc_redirect_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetchBusy,
  input  logic             loadUseHazard,
  input  logic             excReq,
  input  logic             eretReq,
  input  logic [31:0]      epcIn,
  input  logic             branchReq,
  input  logic [31:0]      branchImmIn,
  input  logic             jumpRegReq,
  input  logic [31:0]      jumpRegIn,
  input  logic             jumpImmReq,
  input  logic [25:0]      jumpImmIn,
  output logic             stall,
  output logic             takeException,
  output logic             takeEret,
  output logic             takeBranch,
  output logic             takeJumpReg,
  output logic             takeJumpImm,
  output logic [31:0]      epc,
  output logic [31:0]      branchImmEx,
  output logic [31:0]      jumpReg,
  output logic [25:0]      jumpImm,
  output logic             flushIf,
  output logic             flushId,
  output logic             flushEx,
  output logic             redirectPending,
  output logic [CNT_W-1:0] redirectCount
);

  typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_e;

  // Numeric order of the type codes is the arbitration priority.
  localparam logic [2:0] T_NONE = 3'd0, T_JIMM = 3'd1, T_JREG = 3'd2,
                         T_BR   = 3'd3, T_ERET = 3'd4, T_EXC  = 3'd5;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state, w_state_nxt;
  logic [2:0]       r_ptype, w_sel, w_eff, w_iss;
  logic [31:0]      r_pepc, r_pbr, r_pjr;
  logic [25:0]      r_pji;
  logic [31:0]      w_sel_epc, w_sel_br, w_sel_jr, w_eff_epc, w_eff_br, w_eff_jr;
  logic [25:0]      w_sel_ji, w_eff_ji;
  logic             w_load, w_issue, w_stall, w_repl;
  logic [CNT_W-1:0] r_cnt;

  // ID-stage jumps re-present after a load-use bubble, so they are ignored then.
  always_comb begin
    w_sel = T_NONE;
    if (excReq)                              w_sel = T_EXC;
    else if (eretReq)                        w_sel = T_ERET;
    else if (branchReq)                      w_sel = T_BR;
    else if (jumpRegReq && !loadUseHazard)   w_sel = T_JREG;
    else if (jumpImmReq && !loadUseHazard)   w_sel = T_JIMM;
  end

  assign w_sel_epc = (w_sel == T_ERET) ? epcIn       : '0;
  assign w_sel_br  = (w_sel == T_BR)   ? branchImmIn : '0;
  assign w_sel_jr  = (w_sel == T_JREG) ? jumpRegIn   : '0;
  assign w_sel_ji  = (w_sel == T_JIMM) ? jumpImmIn   : '0;

  // A strictly higher request seen in HOLD pre-empts the parked one.
  assign w_repl    = (r_state == S_HOLD) && (w_sel > r_ptype);
  assign w_eff     = w_repl ? w_sel     : r_ptype;
  assign w_eff_epc = w_repl ? w_sel_epc : r_pepc;
  assign w_eff_br  = w_repl ? w_sel_br  : r_pbr;
  assign w_eff_jr  = w_repl ? w_sel_jr  : r_pjr;
  assign w_eff_ji  = w_repl ? w_sel_ji  : r_pji;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_ptype <= T_NONE;
      r_pepc  <= '0;
      r_pbr   <= '0;
      r_pjr   <= '0;
      r_pji   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_ptype <= w_sel;
        r_pepc  <= w_sel_epc;
        r_pbr   <= w_sel_br;
        r_pjr   <= w_sel_jr;
        r_pji   <= w_sel_ji;
      end else if (w_issue && r_state == S_HOLD) begin
        r_ptype <= T_NONE;
        r_pepc  <= '0;
        r_pbr   <= '0;
        r_pjr   <= '0;
        r_pji   <= '0;
      end
      if (w_issue && r_cnt != '1) r_cnt <= r_cnt + CNT_ONE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    w_iss       = T_NONE;
    w_stall     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (fetchBusy) begin
          w_stall = 1'b1;
          if (w_sel != T_NONE) begin
            w_load      = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (w_sel == T_EXC || w_sel == T_ERET) begin
          w_issue = 1'b1;
          w_iss   = w_sel;
        end else if (loadUseHazard) begin
          w_stall = 1'b1;
          if (w_sel == T_BR) begin
            w_load      = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (w_sel != T_NONE) begin
          w_issue = 1'b1;
          w_iss   = w_sel;
        end
      end
      S_HOLD: begin
        if (!fetchBusy && (!loadUseHazard || w_eff == T_EXC)) begin
          w_issue     = 1'b1;
          w_iss       = w_eff;
          w_state_nxt = S_RUN;
        end else begin
          w_stall = 1'b1;
          w_load  = w_repl;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    stall         = 1'b0;
    takeException = 1'b0;
    takeEret      = 1'b0;
    takeBranch    = 1'b0;
    takeJumpReg   = 1'b0;
    takeJumpImm   = 1'b0;
    flushIf       = 1'b0;
    flushId       = 1'b0;
    flushEx       = 1'b0;
    epc           = '0;
    branchImmEx   = '0;
    jumpReg       = '0;
    jumpImm       = '0;
    if (rst) begin
      stall         = w_stall;
      takeException = w_issue && (w_iss == T_EXC);
      takeEret      = w_issue && (w_iss == T_ERET);
      takeBranch    = w_issue && (w_iss == T_BR);
      takeJumpReg   = w_issue && (w_iss == T_JREG);
      takeJumpImm   = w_issue && (w_iss == T_JIMM);
      flushIf       = w_issue && (w_iss == T_EXC || w_iss == T_ERET);
      flushId       = w_issue && (w_iss == T_EXC || w_iss == T_ERET);
      flushEx       = w_issue && (w_iss == T_EXC);
      if (r_state == S_RUN) begin
        epc = w_sel_epc; branchImmEx = w_sel_br; jumpReg = w_sel_jr; jumpImm = w_sel_ji;
      end else if (w_issue) begin
        epc = w_eff_epc; branchImmEx = w_eff_br; jumpReg = w_eff_jr; jumpImm = w_eff_ji;
      end else begin
        epc = r_pepc; branchImmEx = r_pbr; jumpReg = r_pjr; jumpImm = r_pji;
      end
    end
  end

  assign redirectPending = rst && (r_state == S_HOLD);
  assign redirectCount   = r_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed vector table plus randomized cycles
// checked against a cycle-level reference model of the redirect rules.
module tb_pc_redirect_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fetchBusy, loadUseHazard, excReq, eretReq, branchReq, jumpRegReq, jumpImmReq;
  logic [31:0] epcIn, branchImmIn, jumpRegIn;
  logic [25:0] jumpImmIn;

  logic        stall, takeException, takeEret, takeBranch, takeJumpReg, takeJumpImm;
  logic [31:0] epc, branchImmEx, jumpReg;
  logic [25:0] jumpImm;
  logic        flushIf, flushId, flushEx, redirectPending;
  logic [15:0] redirectCount;

  logic        stall_b, tE_b, tR_b, tB_b, tJR_b, tJI_b, fI_b, fD_b, fX_b, pend_b;
  logic [31:0] epc_b, bimm_b, jreg_b;
  logic [25:0] jimm_b;
  logic [1:0]  cnt_b;

  pc_redirect_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fetchBusy(fetchBusy), .loadUseHazard(loadUseHazard),
    .excReq(excReq), .eretReq(eretReq), .epcIn(epcIn), .branchReq(branchReq),
    .branchImmIn(branchImmIn), .jumpRegReq(jumpRegReq), .jumpRegIn(jumpRegIn),
    .jumpImmReq(jumpImmReq), .jumpImmIn(jumpImmIn), .stall(stall),
    .takeException(takeException), .takeEret(takeEret), .takeBranch(takeBranch),
    .takeJumpReg(takeJumpReg), .takeJumpImm(takeJumpImm), .epc(epc),
    .branchImmEx(branchImmEx), .jumpReg(jumpReg), .jumpImm(jumpImm),
    .flushIf(flushIf), .flushId(flushId), .flushEx(flushEx),
    .redirectPending(redirectPending), .redirectCount(redirectCount));

  pc_redirect_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .fetchBusy(fetchBusy), .loadUseHazard(loadUseHazard),
    .excReq(excReq), .eretReq(eretReq), .epcIn(epcIn), .branchReq(branchReq),
    .branchImmIn(branchImmIn), .jumpRegReq(jumpRegReq), .jumpRegIn(jumpRegIn),
    .jumpImmReq(jumpImmReq), .jumpImmIn(jumpImmIn), .stall(stall_b),
    .takeException(tE_b), .takeEret(tR_b), .takeBranch(tB_b),
    .takeJumpReg(tJR_b), .takeJumpImm(tJI_b), .epc(epc_b),
    .branchImmEx(bimm_b), .jumpReg(jreg_b), .jumpImm(jimm_b),
    .flushIf(fI_b), .flushId(fD_b), .flushEx(fX_b),
    .redirectPending(pend_b), .redirectCount(cnt_b));

  typedef struct packed {
    logic rst, fb, luh, exc, eret, br, jr, ji;
    logic [31:0] pay;
  } in_t;
  typedef struct packed {
    in_t i;
    logic [9:0]  ctl;
    logic [15:0] cnt;
    logic [31:0] pay;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: a pending redirect is just (valid, priority rank, target).
  bit          m_hold, n_hold;
  int          m_t, n_t, m_cnt, n_cnt, m_cnt2, n_cnt2;
  logic [31:0] m_pay, n_pay;

  task automatic cmp(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctl_now();
    return {stall, takeException, takeEret, takeBranch, takeJumpReg, takeJumpImm,
            flushIf, flushId, flushEx, redirectPending};
  endfunction

  function automatic logic [31:0] pay_now();
    return epc | branchImmEx | jumpReg | {6'b0, jumpImm};
  endfunction

  function automatic vec_t mk(input logic r, fb, luh, exc, eret, br, jr, ji,
                              input logic [31:0] pin, input logic [9:0] ctl,
                              input logic [15:0] cnt, input logic [31:0] pout);
    vec_t v;
    v.i = '{r, fb, luh, exc, eret, br, jr, ji, pin};
    v.ctl = ctl; v.cnt = cnt; v.pay = pout;
    return v;
  endfunction

  task automatic apply(input in_t v);
    rst = v.rst; fetchBusy = v.fb; loadUseHazard = v.luh;
    excReq = v.exc; eretReq = v.eret; branchReq = v.br;
    jumpRegReq = v.jr; jumpImmReq = v.ji;
    epcIn = v.pay; branchImmIn = v.pay ^ 32'h0000_0000; jumpRegIn = v.pay;
    jumpImmIn = v.pay[25:0];
  endtask

  // Evaluates the redirect rules for the current inputs and checks every output.
  task automatic model_check(input string name);
    int st, iss, out_t, eff_t;
    logic [31:0] sp, out_p, eff_p;
    logic stl;
    logic [147:0] exp_full, act_full;
    if (!rst) begin
      m_hold = 0; m_t = 0; m_pay = '0; m_cnt = 0; m_cnt2 = 0;
      n_hold = 0; n_t = 0; n_pay = '0; n_cnt = 0; n_cnt2 = 0;
      cmp({name, "_rst"}, {ctl_now(), epc, branchImmEx, jumpReg, jumpImm, redirectCount, 6'(cnt_b)},
          '0);
      return;
    end
    st = 0; sp = '0;
    if (excReq)                        begin st = 5; sp = '0; end
    else if (eretReq)                  begin st = 4; sp = epcIn; end
    else if (branchReq)                begin st = 3; sp = branchImmIn; end
    else if (jumpRegReq && !loadUseHazard) begin st = 2; sp = jumpRegIn; end
    else if (jumpImmReq && !loadUseHazard) begin st = 1; sp = {6'b0, jumpImmIn}; end
    iss = 0; stl = 0; n_hold = m_hold; n_t = m_t; n_pay = m_pay;
    if (!m_hold) begin
      out_t = st; out_p = sp;
      if (fetchBusy) begin
        stl = 1;
        if (st != 0) begin n_hold = 1; n_t = st; n_pay = sp; end
      end else if (st >= 4) iss = st;
      else if (loadUseHazard) begin
        stl = 1;
        if (st == 3) begin n_hold = 1; n_t = st; n_pay = sp; end
      end else iss = st;
    end else begin
      eff_t = (st > m_t) ? st : m_t;
      eff_p = (st > m_t) ? sp : m_pay;
      if (!fetchBusy && (!loadUseHazard || eff_t == 5)) begin
        iss = eff_t; out_t = eff_t; out_p = eff_p;
        n_hold = 0; n_t = 0; n_pay = '0;
      end else begin
        stl = 1; out_t = m_t; out_p = m_pay;
        if (st > m_t) begin n_t = st; n_pay = sp; end
      end
    end
    exp_full = {stl, iss == 5, iss == 4, iss == 3, iss == 2, iss == 1,
                iss >= 4, iss >= 4, iss == 5, m_hold,
                (out_t == 4) ? out_p : 32'h0, (out_t == 3) ? out_p : 32'h0,
                (out_t == 2) ? out_p : 32'h0, (out_t == 1) ? out_p[25:0] : 26'h0,
                16'(m_cnt)};
    act_full = {ctl_now(), epc, branchImmEx, jumpReg, jumpImm, redirectCount};
    cmp(name, act_full, exp_full);
    cmp({name, "_cnt2"}, 160'(cnt_b), 160'(m_cnt2));
    n_cnt  = (iss != 0 && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    n_cnt2 = (iss != 0 && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
  endtask

  task automatic tick();
    @(posedge clk);
    m_hold = n_hold; m_t = n_t; m_pay = n_pay; m_cnt = n_cnt; m_cnt2 = n_cnt2;
    #1;
  endtask

  vec_t tbl[25];
  in_t  rv;

  initial begin
    apply('0);
    m_hold = 0; m_t = 0; m_pay = '0; m_cnt = 0; m_cnt2 = 0;
    n_hold = 0; n_t = 0; n_pay = '0; n_cnt = 0; n_cnt2 = 0;
    @(posedge clk); #1;

    //             rst fb luh exc ert br jr ji  pay_in          ctl     cnt  pay_out
    tbl[0]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h5,          10'h000, 0, 32'h0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h000, 0, 32'h0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 1, 0, 1, 32'h0000_1234,  10'h040, 0, 32'h0000_1234);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h000, 1, 32'h0);
    tbl[4]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 32'h2222_2220,  10'h200, 1, 32'h2222_2220);
    tbl[5]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,          10'h201, 1, 32'h2222_2220);
    tbl[6]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,          10'h201, 1, 32'h2222_2220);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h021, 1, 32'h2222_2220);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h000, 2, 32'h0);
    tbl[9]  = mk(1, 1, 0, 0, 0, 1, 0, 0, 32'h40,         10'h200, 2, 32'h40);
    tbl[10] = mk(1, 1, 0, 1, 0, 0, 0, 0, 32'h55,         10'h201, 2, 32'h40);
    tbl[11] = mk(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,          10'h201, 2, 32'h0);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h10F, 2, 32'h0);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h000, 3, 32'h0);
    tbl[14] = mk(1, 0, 1, 0, 0, 0, 0, 1, 32'habc,        10'h200, 3, 32'h0);
    tbl[15] = mk(1, 0, 1, 0, 1, 0, 0, 1, 32'h1111_1110,  10'h08C, 3, 32'h1111_1110);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h000, 4, 32'h0);
    tbl[17] = mk(1, 0, 1, 0, 0, 1, 0, 0, 32'h80,         10'h200, 4, 32'h80);
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h041, 4, 32'h80);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h000, 5, 32'h0);
    tbl[20] = mk(1, 1, 0, 0, 0, 1, 0, 0, 32'h100,        10'h200, 5, 32'h100);
    tbl[21] = mk(1, 1, 0, 0, 0, 0, 0, 0, 32'h0,          10'h201, 5, 32'h100);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h000, 0, 32'h0);
    tbl[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h000, 0, 32'h0);
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          10'h000, 0, 32'h0);

    for (int k = 0; k < 25; k++) begin
      apply(tbl[k].i);
      #4;
      cmp($sformatf("vec%0d_ctl", k), 160'(ctl_now()), 160'(tbl[k].ctl));
      cmp($sformatf("vec%0d_cnt", k), 160'(redirectCount), 160'(tbl[k].cnt));
      cmp($sformatf("vec%0d_pay", k), 160'(pay_now()), 160'(tbl[k].pay));
      if (k == 21) cmp("sat_cnt2", 160'(cnt_b), 160'(2'd3));
      model_check($sformatf("vec%0d_model", k));
      tick();
    end

    for (int c = 0; c < 4000; c++) begin
      rv.rst  = ($urandom_range(0, 199) != 0);
      rv.fb   = ($urandom_range(0, 2) == 0);
      rv.luh  = ($urandom_range(0, 3) == 0);
      rv.exc  = ($urandom_range(0, 11) == 0);
      rv.eret = ($urandom_range(0, 9) == 0);
      rv.br   = ($urandom_range(0, 3) == 0);
      rv.jr   = ($urandom_range(0, 3) == 0);
      rv.ji   = ($urandom_range(0, 3) == 0);
      rv.pay  = $urandom;
      apply(rv);
      #4;
      model_check($sformatf("rnd%0d", c));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
